// File: rtl/sw_seq_loader.sv
// sw_seq_loader: host byte-stream front end for the Smith-Waterman scoring core.
// Encodes ASCII nucleotides to 2 bits (A=00 C=01 G=10 T=11, case-insensitive),
// buffers one reference (REF_LEN) plus one query (QUERY_LEN) and replays them to
// the core as a gap-free burst of REF_LEN valid cycles, then waits for the core's
// finish pulse before the next burst.
//
// Build option: define SW_SEQ_LOADER_DBUF_EN for two ping-pong banks, so the next
// pair can load while the current one streams. Default build is single bank.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid/in_ready   host character handshake, in_data is the ASCII byte
//   sw_valid            burst valid to the core
//   sw_data_ref/query   2-bit encoded characters to the core (00 when idle)
//   sw_finish           core finish pulse
//   busy                a pair is streaming or awaiting finish
//   err                 sticky flag: an accepted byte was not a nucleotide
module sw_seq_loader #(
  parameter int unsigned REF_LEN   = 64,
  parameter int unsigned QUERY_LEN = 48,
  parameter int unsigned W_CNT     = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       sw_valid,
  output logic [1:0] sw_data_ref,
  output logic [1:0] sw_data_query,
  input  logic       sw_finish,
  output logic       busy,
  output logic       err
);

  localparam int unsigned RI_W = (REF_LEN > 1) ? $clog2(REF_LEN) : 1;
  localparam int unsigned QI_W = (QUERY_LEN > 1) ? $clog2(QUERY_LEN) : 1;
  localparam logic [W_CNT-1:0] REF_LAST = W_CNT'(REF_LEN - 1);
  localparam logic [W_CNT-1:0] QRY_LAST = W_CNT'(QUERY_LEN - 1);
  localparam logic [W_CNT-1:0] QRY_END  = W_CNT'(QUERY_LEN);
  localparam logic [W_CNT-1:0] CNT_ONE  = W_CNT'(1);

  // Returns {illegal, code}; illegal bytes encode as 00.
  function automatic logic [2:0] encode(input logic [7:0] c);
    case (c)
      8'h41, 8'h61: encode = 3'b000;
      8'h43, 8'h63: encode = 3'b001;
      8'h47, 8'h67: encode = 3'b010;
      8'h54, 8'h74: encode = 3'b011;
      default:      encode = 3'b100;
    endcase
  endfunction

  logic       accept;
  logic [2:0] enc;
  logic [1:0] code;
  logic       illegal;

  assign accept  = in_valid & in_ready;
  assign enc     = encode(in_data);
  assign code    = enc[1:0];
  assign illegal = enc[2];

  // Sticky illegal-character flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err <= 1'b0;
    end else if (accept && illegal) begin
      err <= 1'b1;
    end
  end

`ifdef SW_SEQ_LOADER_DBUF_EN

  typedef enum logic {L_REF, L_QRY} load_t;
  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_WAIT} strm_t;

  load_t            lstate;
  strm_t            sstate;
  logic [W_CNT-1:0] lcnt;
  logic [W_CNT-1:0] scnt;
  logic [W_CNT-1:0] nxt_k;
  logic             wr_bank;
  logic             wr_bank_nxt;
  logic             rd_bank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             load_done;
  logic             fin_rel;
  logic             start;
  logic             start_bank;
  logic [1:0]       ref_buf [2][REF_LEN];
  logic [1:0]       qry_buf [2][QUERY_LEN];
  logic [1:0]       ref_first;
  logic [1:0]       qry_first;
  logic [1:0]       ref_nxt;
  logic [1:0]       qry_nxt;

  assign load_done   = accept && (lstate == L_QRY) && (lcnt == QRY_LAST);
  assign fin_rel     = (sstate == S_WAIT) && sw_finish;
  assign wr_bank_nxt = load_done ? ~wr_bank : wr_bank;
  assign nxt_k       = scnt + CNT_ONE;

  // A bank is full from its last query accept until the core finishes with it.
  always_comb begin
    full_nxt = full;
    if (load_done) full_nxt[wr_bank] = 1'b1;
    if (fin_rel)   full_nxt[rd_bank] = 1'b0;
  end

  // Burst launch: a pair completing this cycle counts as available, so the
  // first burst follows the last accept with no extra cycle.
  always_comb begin
    start      = 1'b0;
    start_bank = rd_bank;
    if (sstate == S_IDLE) begin
      start = full[rd_bank] | (load_done & (wr_bank == rd_bank));
    end else if (fin_rel) begin
      start_bank = ~rd_bank;
      start      = full[~rd_bank] | (load_done & (wr_bank == ~rd_bank));
    end
  end

  // Query element 0 may be written on the launch edge when QUERY_LEN is 1.
  assign ref_first = ref_buf[start_bank][0];
  assign qry_first = ((QUERY_LEN == 1) && load_done && (wr_bank == start_bank))
                     ? code : qry_buf[start_bank][0];
  assign ref_nxt   = ref_buf[rd_bank][RI_W'(nxt_k)];
  assign qry_nxt   = (nxt_k < QRY_END) ? qry_buf[rd_bank][QI_W'(nxt_k)] : 2'b00;

  // Character storage into the bank being loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_buf <= '{default: '0};
      qry_buf <= '{default: '0};
    end else if (accept) begin
      if (lstate == L_REF) ref_buf[wr_bank][RI_W'(lcnt)] <= code;
      else                 qry_buf[wr_bank][QI_W'(lcnt)] <= code;
    end
  end

  // Load FSM: fills banks alternately; ready whenever the target bank is free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lstate   <= L_REF;
      lcnt     <= '0;
      wr_bank  <= 1'b0;
      full     <= 2'b00;
      in_ready <= 1'b0;
    end else begin
      full     <= full_nxt;
      wr_bank  <= wr_bank_nxt;
      in_ready <= ~full_nxt[wr_bank_nxt];
      if (accept) begin
        case (lstate)
          L_REF: begin
            if (lcnt == REF_LAST) begin
              lcnt   <= '0;
              lstate <= L_QRY;
            end else begin
              lcnt <= lcnt + CNT_ONE;
            end
          end
          L_QRY: begin
            if (lcnt == QRY_LAST) begin
              lcnt   <= '0;
              lstate <= L_REF;
            end else begin
              lcnt <= lcnt + CNT_ONE;
            end
          end
          default: lstate <= L_REF;
        endcase
      end
    end
  end

  // Stream FSM: replays banks in order 0,1,0,... to the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sstate        <= S_IDLE;
      scnt          <= '0;
      rd_bank       <= 1'b0;
      sw_valid      <= 1'b0;
      sw_data_ref   <= 2'b00;
      sw_data_query <= 2'b00;
      busy          <= 1'b0;
    end else begin
      case (sstate)
        S_IDLE: begin
          if (start) begin
            sstate        <= S_STREAM;
            scnt          <= '0;
            sw_valid      <= 1'b1;
            busy          <= 1'b1;
            sw_data_ref   <= ref_first;
            sw_data_query <= qry_first;
          end
        end
        S_STREAM: begin
          if (scnt == REF_LAST) begin
            sstate        <= S_WAIT;
            scnt          <= '0;
            sw_valid      <= 1'b0;
            sw_data_ref   <= 2'b00;
            sw_data_query <= 2'b00;
          end else begin
            scnt          <= nxt_k;
            sw_data_ref   <= ref_nxt;
            sw_data_query <= qry_nxt;
          end
        end
        S_WAIT: begin
          if (sw_finish) begin
            rd_bank <= ~rd_bank;
            if (start) begin
              sstate        <= S_STREAM;
              scnt          <= '0;
              sw_valid      <= 1'b1;
              sw_data_ref   <= ref_first;
              sw_data_query <= qry_first;
            end else begin
              sstate <= S_IDLE;
              busy   <= 1'b0;
            end
          end
        end
        default: sstate <= S_IDLE;
      endcase
    end
  end

`else

  typedef enum logic [1:0] {LOAD_REF, LOAD_QRY, STREAM, WAIT_FIN} state_t;

  state_t           state;
  logic [W_CNT-1:0] cnt;
  logic [W_CNT-1:0] nxt_k;
  logic [1:0]       ref_buf [REF_LEN];
  logic [1:0]       qry_buf [QUERY_LEN];
  logic [1:0]       qry_first;
  logic [1:0]       ref_nxt;
  logic [1:0]       qry_nxt;

  assign nxt_k     = cnt + CNT_ONE;
  // Query element 0 is being written on the launch edge when QUERY_LEN is 1.
  assign qry_first = (QUERY_LEN == 1) ? code : qry_buf[0];
  assign ref_nxt   = ref_buf[RI_W'(nxt_k)];
  assign qry_nxt   = (nxt_k < QRY_END) ? qry_buf[QI_W'(nxt_k)] : 2'b00;

  // Character storage; accepts only occur in the two load states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_buf <= '{default: '0};
      qry_buf <= '{default: '0};
    end else if (accept) begin
      if (state == LOAD_REF)      ref_buf[RI_W'(cnt)] <= code;
      else if (state == LOAD_QRY) qry_buf[QI_W'(cnt)] <= code;
    end
  end

  // Main FSM: load ref, load query, burst, wait for the core.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= LOAD_REF;
      cnt           <= '0;
      in_ready      <= 1'b0;
      sw_valid      <= 1'b0;
      sw_data_ref   <= 2'b00;
      sw_data_query <= 2'b00;
      busy          <= 1'b0;
    end else begin
      case (state)
        LOAD_REF: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (cnt == REF_LAST) begin
              cnt   <= '0;
              state <= LOAD_QRY;
            end else begin
              cnt <= nxt_k;
            end
          end
        end
        LOAD_QRY: begin
          in_ready <= 1'b1;
          if (accept) begin
            if (cnt == QRY_LAST) begin
              cnt           <= '0;
              state         <= STREAM;
              in_ready      <= 1'b0;
              sw_valid      <= 1'b1;
              busy          <= 1'b1;
              sw_data_ref   <= ref_buf[0];
              sw_data_query <= qry_first;
            end else begin
              cnt <= nxt_k;
            end
          end
        end
        STREAM: begin
          if (cnt == REF_LAST) begin
            cnt           <= '0;
            state         <= WAIT_FIN;
            sw_valid      <= 1'b0;
            sw_data_ref   <= 2'b00;
            sw_data_query <= 2'b00;
          end else begin
            cnt           <= nxt_k;
            sw_data_ref   <= ref_nxt;
            sw_data_query <= qry_nxt;
          end
        end
        WAIT_FIN: begin
          if (sw_finish) begin
            state    <= LOAD_REF;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: state <= LOAD_REF;
      endcase
    end
  end

`endif

endmodule

// File: doc/sw_seq_loader.md
Name: sw_seq_loader

Overview:
- Upstream feeder for the Smith-Waterman scoring core.
- Accepts nucleotide characters from a host byte stream with a valid/ready handshake and encodes each one to 2 bits.
- Buffers one reference sequence (REF_LEN) and one query sequence (QUERY_LEN), then drives the core's serial input as one contiguous burst of REF_LEN valid cycles.
- Holds off the next burst until the core pulses finish.

Parameters:
- REF_LEN, 64, reference length in characters; also the stream burst length.
- QUERY_LEN, 48, query length in characters; must be ≤ REF_LEN.
- W_CNT, 7, counter width; must satisfy 2^W_CNT > REF_LEN.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  host character valid
- in_ready  out  1  loader can accept a character
- in_data  in  8  ASCII character
- sw_valid  out  1  to core valid
- sw_data_ref  out  2  to core data_ref
- sw_data_query  out  2  to core data_query
- sw_finish  in  1  core finish pulse
- busy  out  1  a pair is streaming or awaiting finish
- err  out  1  sticky illegal-character flag

Behaviour:
- Encoding:
  - A/a=00, C/c=01, G/g=10, T/t=11.
  - Any other byte is stored as 00 and sets err. err is sticky until reset.
- Accept rule:
  - A character is accepted on a rising clk when in_valid && in_ready.
  - in_data is sampled only on accept.
- Load order: the first REF_LEN accepted characters fill ref[0..REF_LEN-1] in order; the next QUERY_LEN fill query[0..QUERY_LEN-1].
- Main FSM states (single-buffer build):
  - LOAD_REF: in_ready=1. The load counter increments per accept. On the accept of ref index REF_LEN-1, go to LOAD_QRY and clear the counter.
  - LOAD_QRY: in_ready=1. On the accept of query index QUERY_LEN-1, go to STREAM and clear the counter.
  - STREAM: in_ready=0, sw_valid=1 for exactly REF_LEN consecutive cycles, k=0..REF_LEN-1.
    - sw_data_ref=ref[k].
    - sw_data_query=query[k] for k<QUERY_LEN, else 00.
    - After the k=REF_LEN-1 cycle, go to WAIT_FIN.
  - WAIT_FIN: in_ready=0, sw_valid=0. On sw_finish=1, go to LOAD_REF. in_ready is 1 in the next cycle.
- Latency: the first sw_valid=1 cycle is the cycle immediately after the last query accept. There are no bubbles inside a burst.
- sw_valid is registered; it is never asserted outside STREAM.
- sw_data_* are 00 whenever sw_valid=0.
- sw_finish outside WAIT_FIN is ignored. This includes during STREAM and does not shorten the burst.
- busy=1 in STREAM and WAIT_FIN, else 0.
- Reset (async, any state including mid-burst):
  - State=LOAD_REF, counters=0, buffers=0, err=0, sw_valid=0, sw_data_*=00, busy=0.
  - in_ready=0 while reset is asserted, and 1 from the first clk after deassertion.
- in_valid held with in_ready=0: no accept and no state change; the character is not lost from the host's view.

Optional Feature:
- Macro SW_SEQ_LOADER_DBUF_EN.
- Defined: two buffer banks with separate load and stream FSMs.
  - Loading into the idle bank proceeds while the other bank is in STREAM/WAIT_FIN. in_ready=1 unless both banks are full.
  - A full bank starts streaming on the cycle after the core becomes free: sw_finish seen, or the first pair after reset. Banks alternate 0,1,0,...
  - busy reflects the streaming bank only.
- Undefined: single bank, behaviour exactly as above, with in_ready=0 in STREAM/WAIT_FIN.

Test Plan:
- Reset, then 64 × "ACGT" repeating plus 48 × "T" -> sw_valid high for exactly 64 consecutive cycles starting the cycle after the 112th accept.
  - sw_data_ref = 00,01,10,11,...
  - sw_data_query = 11 for k=0..47 and 00 for k=48..63.
  - in_ready=0 until sw_finish is pulsed 5 cycles later; in_ready=1 the next cycle.
- Host toggles in_valid randomly with 50% duty during load -> identical burst content to scenario 1, and no characters dropped or duplicated.
- Ref character 5 is 'N' and query character 0 is 'x' -> those positions stream 00; err rises on the accept cycle and stays 1 through the next pair until reset.
- Assert reset at burst cycle k=20 -> sw_valid=0 immediately (async).
  - After release, a fresh 112-character load produces a full 64-cycle burst with the new data.
  - err=0 and no residual data appears.
- Pulse sw_finish during STREAM at k=10 -> burst still runs all 64 cycles; FSM stays in WAIT_FIN until a later sw_finish.
- DBUF_EN: load pair A, then immediately pair B during A's burst -> in_ready stays 1 for B's 112 characters and then drops.
  - B's burst begins 1 cycle after A's sw_finish.
  - Data order is A then B.
